// File: rtl/mod_swapchain.sv
// Modulation segment/index sequencer: turns latched modulation settings into the live BRAM read
// segment and sample index, with loop-boundary segment swaps, finite repetition and stop.
//
// state    | meaning
// RUN      | free-running loop on the current segment
// PENDING  | swap to req_seg requested, taken at the next loop boundary
// FINITE   | counting down remaining loops on the current segment
// STOPPED  | finite playback finished, index frozen at cycle
// RESTART  | stopped, settings updated, waiting for the next tick to restart

package mod_swapchain_pkg;
  localparam int CYCLE_W = 15;

  typedef struct packed {
    logic               req_rd_segment;
    logic [CYCLE_W-1:0] cycle_0;
    logic [CYCLE_W-1:0] cycle_1;
    logic [31:0]        freq_div_0;
    logic [31:0]        freq_div_1;
    logic [31:0]        rep;
  } mod_settings_t;
endpackage

module mod_swapchain
  import mod_swapchain_pkg::*;
#(
  parameter int          IDX_W   = CYCLE_W,
  parameter logic [31:0] REP_INF = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             update_settings,
  input  mod_settings_t    mod_settings,
  input  logic             tick,
  output logic             segment,
  output logic [IDX_W-1:0] idx,
  output logic             stop,
  output logic             segment_changed
);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PENDING,
    ST_FINITE,
    ST_STOPPED,
    ST_RESTART
  } state_t;

  state_t           state_q, state_eff, state_d;
  logic             upd_seen_q;
  logic [IDX_W-1:0] cyc0_q, cyc1_q;
  logic [31:0]      fdiv0_q, fdiv1_q, rep_q;
  logic             req_seg_q;
  logic [31:0]      div_cnt_q, loop_cnt_q;

  logic [IDX_W-1:0] cyc_cur;
  logic [31:0]      fdiv_cur, fdiv_eff;
  logic             step, wrap;

  logic             seg_d, stop_d, chg_d;
  logic [IDX_W-1:0] idx_d;
  logic [31:0]      div_d, loop_d;

  always_comb begin
    cyc_cur  = segment ? cyc1_q : cyc0_q;
    fdiv_cur = segment ? fdiv1_q : fdiv0_q;
    fdiv_eff = (fdiv_cur == 32'd0) ? 32'd1 : fdiv_cur;
    // >= rather than == so a divider shrink below div_cnt steps at once instead of wrapping 2^32
    step     = tick && (div_cnt_q >= fdiv_eff - 32'd1);
    wrap     = step && (idx >= cyc_cur);
  end

  // An update is resolved one cycle after its latch, against the freshly latched req_seg.
  always_comb begin
    state_eff = state_q;
    if (upd_seen_q) begin
      unique case (state_q)
        ST_STOPPED, ST_RESTART: state_eff = ST_RESTART;
        ST_PENDING:             state_eff = (req_seg_q != segment) ? ST_PENDING : ST_RUN;
        default:                state_eff = (req_seg_q != segment) ? ST_PENDING : state_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_eff;
    seg_d   = segment;
    idx_d   = idx;
    div_d   = div_cnt_q;
    loop_d  = loop_cnt_q;
    stop_d  = stop;
    chg_d   = 1'b0;
    unique case (state_eff)
      ST_RUN, ST_PENDING, ST_FINITE: begin
        if (tick) begin
          if (step) begin
            div_d = 32'd0;
            idx_d = wrap ? '0 : idx + IDX_W'(1);
          end else begin
            div_d = div_cnt_q + 32'd1;
          end
          if (wrap) begin
            if (state_eff == ST_PENDING) begin
              seg_d   = req_seg_q;
              chg_d   = (req_seg_q != segment);
              loop_d  = rep_q;
              state_d = (rep_q == REP_INF) ? ST_RUN : ST_FINITE;
            end else if (state_eff == ST_FINITE) begin
              if (loop_cnt_q == 32'd0) begin
                state_d = ST_STOPPED;
                idx_d   = cyc_cur;
                stop_d  = 1'b1;
              end else begin
                loop_d = loop_cnt_q - 32'd1;
              end
            end
          end
        end
      end
      ST_RESTART: begin
        if (tick) begin
          seg_d   = req_seg_q;
          chg_d   = (req_seg_q != segment);
          idx_d   = '0;
          div_d   = 32'd0;
          stop_d  = 1'b0;
          loop_d  = rep_q;
          state_d = (rep_q == REP_INF) ? ST_RUN : ST_FINITE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      segment         <= 1'b0;
      idx             <= '0;
      stop            <= 1'b0;
      segment_changed <= 1'b0;
      div_cnt_q       <= 32'd0;
      loop_cnt_q      <= 32'd0;
      upd_seen_q      <= 1'b0;
      cyc0_q          <= '0;
      cyc1_q          <= '0;
      fdiv0_q         <= 32'd1;
      fdiv1_q         <= 32'd1;
      rep_q           <= REP_INF;
      req_seg_q       <= 1'b0;
    end else begin
      segment         <= seg_d;
      idx             <= idx_d;
      stop            <= stop_d;
      segment_changed <= chg_d;
      div_cnt_q       <= div_d;
      loop_cnt_q      <= loop_d;
      upd_seen_q      <= update_settings;
      if (update_settings) begin
        cyc0_q    <= mod_settings.cycle_0;
        cyc1_q    <= mod_settings.cycle_1;
        fdiv0_q   <= mod_settings.freq_div_0;
        fdiv1_q   <= mod_settings.freq_div_1;
        rep_q     <= mod_settings.rep;
        req_seg_q <= mod_settings.req_rd_segment;
      end
    end
  end

endmodule

// File: tb/tb_mod_swapchain.sv
// Bench for mod_swapchain: directed scenarios plus random traffic, checked against a
// flag-based behavioural model of segment playback.
module tb_mod_swapchain;
  import mod_swapchain_pkg::*;

  localparam logic [31:0] INF = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          update_settings = 1'b0;
  logic          tick = 1'b0;
  mod_settings_t mod_settings = '0;
  logic          segment;
  logic [14:0]   idx;
  logic          stop;
  logic          segment_changed;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mod_swapchain dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .update_settings (update_settings),
    .mod_settings    (mod_settings),
    .tick            (tick),
    .segment         (segment),
    .idx             (idx),
    .stop            (stop),
    .segment_changed (segment_changed)
  );

  // Behavioural model: playback mode kept as independent flags.
  bit          m_seg, m_stop, m_chg;
  int unsigned m_idx;
  longint      m_div;
  longint      m_loops;
  bit          m_pending, m_finite, m_halted, m_armed, m_upd_prev;
  int unsigned s_cyc [2];
  longint      s_div [2];
  logic [31:0] s_rep;
  bit          s_req;

  task automatic model_reset();
    m_seg = 0; m_stop = 0; m_chg = 0; m_idx = 0; m_div = 0; m_loops = 0;
    m_pending = 0; m_finite = 0; m_halted = 0; m_armed = 0; m_upd_prev = 0;
    s_cyc[0] = 0; s_cyc[1] = 0; s_div[0] = 1; s_div[1] = 1; s_rep = INF; s_req = 0;
  endtask

  task automatic start_playing();
    m_pending = 0;
    m_finite  = (s_rep != INF);
    m_loops   = longint'(s_rep);
  endtask

  task automatic model_edge(bit upd, mod_settings_t ms, bit tk);
    int unsigned cyc;
    longint      dv;
    m_chg = 0;
    if (m_upd_prev) begin
      if (m_halted || m_armed) m_armed = 1;
      else if (s_req != m_seg) begin m_pending = 1; m_finite = 0; end
      else if (m_pending) m_pending = 0;
    end
    cyc = s_cyc[m_seg];
    dv  = (s_div[m_seg] == 0) ? 1 : s_div[m_seg];
    if (tk) begin
      if (m_armed) begin
        m_chg = (s_req != m_seg);
        m_seg = s_req; m_idx = 0; m_div = 0; m_stop = 0;
        m_armed = 0; m_halted = 0;
        start_playing();
      end else if (!m_halted) begin
        if (m_div + 1 >= dv) begin
          m_div = 0;
          if (m_idx >= cyc) begin
            if (m_pending) begin
              m_chg = (s_req != m_seg);
              m_seg = s_req; m_idx = 0;
              start_playing();
            end else if (m_finite && m_loops == 0) begin
              m_halted = 1; m_stop = 1; m_idx = cyc;
            end else begin
              if (m_finite) m_loops--;
              m_idx = 0;
            end
          end else begin
            m_idx++;
          end
        end else begin
          m_div++;
        end
      end
    end
    if (upd) begin
      s_cyc[0] = ms.cycle_0; s_cyc[1] = ms.cycle_1;
      s_div[0] = ms.freq_div_0; s_div[1] = ms.freq_div_1;
      s_rep = ms.rep; s_req = ms.req_rd_segment;
    end
    m_upd_prev = upd;
  endtask

  task automatic check(string tag, logic [31:0] obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".segment"}, {31'b0, segment}, int'(m_seg));
    check({tag, ".idx"}, {17'b0, idx}, int'(m_idx));
    check({tag, ".stop"}, {31'b0, stop}, int'(m_stop));
    check({tag, ".changed"}, {31'b0, segment_changed}, int'(m_chg));
  endtask

  task automatic cyc(bit upd, mod_settings_t ms, bit tk, string tag);
    update_settings = upd;
    mod_settings    = ms;
    tick            = tk;
    @(posedge clk);
    model_edge(upd, ms, tk);
    #1;
    update_settings = 1'b0;
    tick            = 1'b0;
    check_model(tag);
  endtask

  function automatic mod_settings_t mk(bit req, int c0, int c1, int d0, int d1, logic [31:0] rep);
    mod_settings_t s;
    s.req_rd_segment = req;
    s.cycle_0 = 15'(c0); s.cycle_1 = 15'(c1);
    s.freq_div_0 = 32'(d0); s.freq_div_1 = 32'(d1);
    s.rep = rep;
    return s;
  endfunction

  initial begin
    mod_settings_t cur;
    int t1_idx [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int t2_seg [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
    int t2_idx [9] = '{2, 3, 0, 1, 0, 1, 0, 1, 1};
    int t2_stp [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int t6_idx [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
    int cnt;

    model_reset();
    #2;
    check_model("reset");
    #10 reset_n = 1'b1;
    @(posedge clk); model_edge(0, '0, 0); #1;

    // T1: divide by 2 on segment 0
    cur = mk(0, 3, 1, 2, 1, INF);
    cyc(1, cur, 0, "t1_upd");
    check("t1_idx_initial", {17'b0, idx}, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, cur, 1, "t1");
      check("t1_idx_const", {17'b0, idx}, t1_idx[i]);
    end

    // T2/T3: request segment 1 at idx 1, then finite playback REP=2
    cur = mk(0, 3, 1, 1, 1, 2);
    cyc(1, cur, 0, "t2_upd_same");
    cyc(0, cur, 1, "t2_pre");
    check("t2_idx_at_req", {17'b0, idx}, 1);
    cur.req_rd_segment = 1'b1;
    cyc(1, cur, 0, "t2_upd_swap");
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(0, cur, 1, "t2");
      check("t2_seg_const", {31'b0, segment}, t2_seg[i]);
      check("t2_idx_const", {17'b0, idx}, t2_idx[i]);
      check("t2_stop_const", {31'b0, stop}, t2_stp[i]);
      if (segment_changed) cnt++;
    end
    check("t2_changed_pulses", cnt, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, cur, 1, "t3_frozen");
      check("t3_idx_frozen", {17'b0, idx}, 1);
    end

    // T4: restart from STOPPED onto segment 0, forever
    cur = mk(0, 3, 1, 1, 1, INF);
    cyc(1, cur, 0, "t4_upd");
    check("t4_still_stopped", {31'b0, stop}, 1);
    cyc(0, cur, 1, "t4_restart");
    check("t4_seg_restart", {31'b0, segment}, 0);
    check("t4_changed_restart", {31'b0, segment_changed}, 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, cur, 1, "t4_run");
      if (idx == 0) cnt++;
    end
    check("t4_wraps", cnt, 3);

    // T5: request then cancel before the wrap
    cur.req_rd_segment = 1'b1;
    cyc(1, cur, 0, "t5_req");
    cur.req_rd_segment = 1'b0;
    cyc(1, cur, 0, "t5_cancel");
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, cur, 1, "t5");
      if (segment_changed || segment) cnt++;
    end
    check("t5_no_swap", cnt, 0);

    // T6: update with tick in the same cycle, divider 1 -> 4
    cur = mk(0, 3, 1, 4, 1, INF);
    for (int i = 0; i < 9; i++) begin
      cyc(i == 0, cur, 1, "t6");
      check("t6_idx_const", {17'b0, idx}, t6_idx[i]);
    end

    // Reset in the middle of finite playback on segment 1
    cur = mk(1, 3, 1, 1, 1, 3);
    cyc(1, cur, 0, "rst_upd");
    for (int i = 0; i < 3; i++) cyc(0, cur, 1, "rst_fin");
    check("rst_on_seg1", {31'b0, segment}, 1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    check("async_reset_idx", {17'b0, idx}, 0);
    #3 reset_n = 1'b1;
    @(posedge clk); model_edge(0, '0, 0); #1;
    check_model("post_reset");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit upd, tk;
      logic [31:0] rep;
      upd = ($urandom_range(0, 15) == 0);
      tk  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: rep = 0;
        1: rep = 1;
        2: rep = 2;
        default: rep = INF;
      endcase
      if (upd)
        cur = mk($urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 5),
                 $urandom_range(0, 3), $urandom_range(0, 3), rep);
      cyc(upd, cur, tk, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
